// File: rtl/ram_cmd_arbiter_if.sv
// Signal bundle for ram_cmd_arbiter: SPI word link, local host port and single-port RAM port.
// The arbiter connects through the slave modport; the surrounding environment uses master.
interface ram_cmd_arbiter_if #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 8
);
  localparam int unsigned RxW = 10;

  logic                 rx_valid;
  logic [RxW-1:0]       rx_data;
  logic                 tx_valid;
  logic [DATA_SIZE-1:0] tx_data;

  logic                 host_req;
  logic                 host_we;
  logic [ADDR_SIZE-1:0] host_addr;
  logic [DATA_SIZE-1:0] host_wdata;
  logic                 host_gnt;
  logic                 host_rvalid;
  logic [DATA_SIZE-1:0] host_rdata;

  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [DATA_SIZE-1:0] ram_wdata;
  logic [DATA_SIZE-1:0] ram_rdata;

  logic                 busy;
  logic                 spi_ovf;

  modport slave (
    input  rx_valid, rx_data, host_req, host_we, host_addr, host_wdata, ram_rdata,
    output tx_valid, tx_data, host_gnt, host_rvalid, host_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, busy, spi_ovf
  );

  modport master (
    output rx_valid, rx_data, host_req, host_we, host_addr, host_wdata, ram_rdata,
    input  tx_valid, tx_data, host_gnt, host_rvalid, host_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, busy, spi_ovf
  );
endinterface

// File: rtl/ram_cmd_arbiter.sv
// Shares one synchronous single-port RAM between an SPI command stream and a local host,
// with round-robin arbitration and registered, state-decoded RAM/handshake outputs.
module ram_cmd_arbiter #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 8
) (
  input logic             clk,
  input logic             rst,
  ram_cmd_arbiter_if.slave bus
);
  localparam int unsigned PayW = 8;
  localparam logic [1:0]  CMD_WADDR = 2'b00;
  localparam logic [1:0]  CMD_WDATA = 2'b01;
  localparam logic [1:0]  CMD_RADDR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, SPI_WR, SPI_RD, SPI_RD_WAIT, HOST_WR, HOST_RD, HOST_RD_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic                 spi_pend_q, spi_pend_d;
  logic                 spi_ovf_q, spi_ovf_d;
  logic                 snap_we_q, snap_we_d;
  logic [ADDR_SIZE-1:0] snap_addr_q, snap_addr_d;
  logic [DATA_SIZE-1:0] snap_wdata_q, snap_wdata_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 prio_host_q, prio_host_d;

  logic                 tx_valid_q, tx_valid_d;
  logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 host_gnt_q, host_gnt_d;
  logic                 host_rvalid_q, host_rvalid_d;
  logic [DATA_SIZE-1:0] host_rdata_q, host_rdata_d;
  logic                 ram_en_q, ram_en_d;
  logic                 ram_we_q, ram_we_d;
  logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_SIZE-1:0] ram_wdata_q, ram_wdata_d;
  logic                 busy_q, busy_d;

  logic [1:0]           rx_cmd;
  logic [PayW-1:0]      rx_pay;
  logic                 spi_done;

  // Next-state, SPI command capture and registered output decode
  always_comb begin
    state_d       = state_q;
    spi_pend_d    = spi_pend_q;
    spi_ovf_d     = spi_ovf_q;
    snap_we_d     = snap_we_q;
    snap_addr_d   = snap_addr_q;
    snap_wdata_d  = snap_wdata_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    prio_host_d   = prio_host_q;
    tx_valid_d    = 1'b0;
    tx_data_d     = tx_data_q;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    host_gnt_d    = 1'b0;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = '0;
    ram_wdata_d   = '0;
    busy_d        = 1'b0;

    rx_cmd   = bus.rx_data[9:8];
    rx_pay   = bus.rx_data[PayW-1:0];
    spi_done = (state_q == SPI_WR) || (state_q == SPI_RD_WAIT);

    // A data word landing on the completing edge re-arms the pending slot instead of overflowing
    if (spi_done) spi_pend_d = 1'b0;
    if (bus.rx_valid) begin
      case (rx_cmd)
        CMD_WADDR: wr_addr_d = ADDR_SIZE'(rx_pay);
        CMD_RADDR: rd_addr_d = ADDR_SIZE'(rx_pay);
        default: begin
          if (spi_pend_q && !spi_done) begin
            spi_ovf_d = 1'b1;
          end else begin
            spi_pend_d = 1'b1;
            snap_we_d  = (rx_cmd == CMD_WDATA);
            if (rx_cmd == CMD_WDATA) begin
              snap_addr_d  = wr_addr_q;
              snap_wdata_d = DATA_SIZE'(rx_pay);
            end else begin
              snap_addr_d  = rd_addr_q;
            end
          end
        end
      endcase
    end

    case (state_q)
      IDLE: begin
        if (spi_pend_q && (!bus.host_req || !prio_host_q)) begin
          state_d     = snap_we_q ? SPI_WR : SPI_RD;
          prio_host_d = 1'b1;
        end else if (bus.host_req) begin
          state_d     = bus.host_we ? HOST_WR : HOST_RD;
          prio_host_d = 1'b0;
        end
      end
      SPI_RD:  state_d = SPI_RD_WAIT;
      HOST_RD: state_d = HOST_RD_WAIT;
      SPI_RD_WAIT: begin
        state_d    = IDLE;
        tx_valid_d = 1'b1;
        tx_data_d  = bus.ram_rdata;
      end
      HOST_RD_WAIT: begin
        state_d       = IDLE;
        host_rvalid_d = 1'b1;
        host_rdata_d  = bus.ram_rdata;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the upcoming state so they register in step with it
    case (state_d)
      SPI_WR: begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = snap_addr_q;
        ram_wdata_d = snap_wdata_q;
      end
      SPI_RD: begin
        ram_en_d    = 1'b1;
        ram_addr_d  = snap_addr_q;
        ram_wdata_d = snap_wdata_q;
      end
      HOST_WR: begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = bus.host_addr;
        ram_wdata_d = bus.host_wdata;
        host_gnt_d  = 1'b1;
      end
      HOST_RD: begin
        ram_en_d    = 1'b1;
        ram_addr_d  = bus.host_addr;
        ram_wdata_d = bus.host_wdata;
        host_gnt_d  = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      spi_pend_q    <= 1'b0;
      spi_ovf_q     <= 1'b0;
      snap_we_q     <= 1'b0;
      snap_addr_q   <= '0;
      snap_wdata_q  <= '0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      prio_host_q   <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      spi_pend_q    <= spi_pend_d;
      spi_ovf_q     <= spi_ovf_d;
      snap_we_q     <= snap_we_d;
      snap_addr_q   <= snap_addr_d;
      snap_wdata_q  <= snap_wdata_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      prio_host_q   <= prio_host_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      host_gnt_q    <= host_gnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.host_gnt    = host_gnt_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.ram_en      = ram_en_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.busy        = busy_q;
  assign bus.spi_ovf     = spi_ovf_q;
endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Self-checking bench for ram_cmd_arbiter: vector table, hand-timed corner sequences and a
// randomized SPI/host mix checked against a memory-image reference model.
module tb_ram_cmd_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_cmd_arbiter_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();
  ram_cmd_arbiter #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Synchronous single-port RAM attached to the DUT, plus a bench-side fill strobe
  logic [7:0] ram [256];
  logic [7:0] mem_model [256];
  logic       bd_fill;

  function automatic logic [7:0] init_val(int i);
    return 8'(i * 37 + 11);
  endfunction

  always @(posedge clk) begin
    if (bd_fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata <= ram[bus.ram_addr];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_word(input logic [9:0] w);
    bus.rx_valid = 1'b1;
    bus.rx_data  = w;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_rst_ctrl"}, 32'({bus.tx_valid, bus.host_gnt, bus.host_rvalid, bus.ram_en,
                                   bus.ram_we, bus.busy, bus.spi_ovf}), 32'd0);
    check({tag, "_rst_data"}, 32'({bus.tx_data, bus.host_rdata, bus.ram_addr, bus.ram_wdata}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.host_gnt) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.tx_valid) begin ok = 1'b1; return; end
    end
  endtask

  typedef struct {
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] ra;
    logic [7:0] exp_tx;
  } vec_t;
  vec_t vecs [6];

  int  spi_ops, host_ops, ss_cnt, tx_cnt, bad;
  bit  ok, ok2, prev_s;
  logic [7:0] sa, sd, ha, hd;
  logic       hwe;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; bd_fill = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.host_req = 1'b0;
    bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    for (int i = 0; i < 256; i++) mem_model[i] = init_val(i);
    vecs[0] = '{8'h05, 8'hA5, 8'h05, 8'hA5};
    vecs[1] = '{8'h3A, 8'h00, 8'h3A, 8'h00};
    vecs[2] = '{8'hFF, 8'h5C, 8'hFF, 8'h5C};
    vecs[3] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[4] = '{8'h22, 8'h81, 8'h05, 8'hA5};
    vecs[5] = '{8'h23, 8'h11, 8'h06, 8'hE9};
    @(negedge clk);
    bd_fill = 1'b0;
    do_reset("init");

    // Table: SPI write (addr word, data word) then SPI read, exact-cycle checks
    foreach (vecs[i]) begin
      spi_word({2'b00, vecs[i].wa});
      spi_word({2'b01, vecs[i].wd});
      @(negedge clk);
      check("tbl_wr_en_we", 32'({bus.ram_en, bus.ram_we, bus.busy}), 32'b111);
      check("tbl_wr_addr", 32'(bus.ram_addr), 32'(vecs[i].wa));
      check("tbl_wr_data", 32'(bus.ram_wdata), 32'(vecs[i].wd));
      mem_model[vecs[i].wa] = vecs[i].wd;
      @(negedge clk);
      check("tbl_wr_single", 32'(bus.ram_en), 32'd0);
      spi_word({2'b10, vecs[i].ra});
      spi_word(10'h300);
      @(negedge clk);
      check("tbl_rd_en_we", 32'({bus.ram_en, bus.ram_we}), 32'b10);
      check("tbl_rd_addr", 32'(bus.ram_addr), 32'(vecs[i].ra));
      @(negedge clk);
      check("tbl_tx_early", 32'(bus.tx_valid), 32'd0);
      @(negedge clk);
      check("tbl_tx_valid", 32'(bus.tx_valid), 32'd1);
      check("tbl_tx_data", 32'(bus.tx_data), 32'(vecs[i].exp_tx));
      @(negedge clk);
      check("tbl_tx_pulse", 32'(bus.tx_valid), 32'd0);
      check("tbl_tx_hold", 32'(bus.tx_data), 32'(vecs[i].exp_tx));
    end

    // SPI and host tie right after reset: SPI first, host one idle cycle later
    do_reset("s3");
    spi_word(10'h020);
    spi_word(10'h15A);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h10;
    @(negedge clk);
    check("s3_spi_first", 32'({bus.ram_en, bus.ram_we, bus.host_gnt}), 32'b110);
    check("s3_spi_addr", 32'(bus.ram_addr), 32'h20);
    mem_model[8'h20] = 8'h5A;
    @(negedge clk);
    check("s3_idle_gap", 32'({bus.busy, bus.host_gnt}), 32'd0);
    @(negedge clk);
    check("s3_host_gnt", 32'({bus.host_gnt, bus.ram_en, bus.ram_we}), 32'b110);
    check("s3_host_addr", 32'(bus.ram_addr), 32'h10);
    bus.host_req = 1'b0;
    @(negedge clk);
    check("s3_rvalid_early", 32'(bus.host_rvalid), 32'd0);
    @(negedge clk);
    check("s3_rvalid", 32'(bus.host_rvalid), 32'd1);
    check("s3_rdata", 32'(bus.host_rdata), 32'(mem_model[8'h10]));

    // Host holds its request while SPI writes arrive every 6 cycles
    do_reset("s4");
    spi_word(10'h001);
    spi_ops = 0; host_ops = 0; ss_cnt = 0; prev_s = 1'b0;
    fork
      begin
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h80; bus.host_wdata = 8'h77;
        repeat (40) @(negedge clk);
        wait_gnt(ok);
        bus.host_req = 1'b0;
        check("s4_host_final_gnt", 32'(ok), 32'd1);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          spi_word({2'b01, 8'(8'hC0 + k)});
          repeat (5) @(negedge clk);
        end
      end
      begin
        repeat (50) begin
          @(negedge clk);
          if (bus.ram_en) begin
            if (bus.host_gnt) begin host_ops++; prev_s = 1'b0; end
            else begin
              spi_ops++;
              if (prev_s) ss_cnt++;
              prev_s = 1'b1;
            end
          end
        end
      end
    join
    mem_model[8'h80] = 8'h77;
    mem_model[8'h01] = 8'hC5;
    check("s4_spi_ops", 32'(spi_ops), 32'd6);
    check("s4_host_ops_ge6", 32'(host_ops >= 6), 32'd1);
    check("s4_no_spi_back2back", 32'(ss_cnt), 32'd0);
    check("s4_no_ovf", 32'(bus.spi_ovf), 32'd0);

    // Two read-data words back to back while the host owns the RAM
    do_reset("s5");
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h90;
    @(negedge clk);
    check("s5_host_gnt", 32'(bus.host_gnt), 32'd1);
    bus.host_req = 1'b0;
    bus.rx_valid = 1'b1; bus.rx_data = 10'h300;
    @(negedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("s5_ovf_set", 32'(bus.spi_ovf), 32'd1);
    check("s5_host_rdata", 32'({bus.host_rvalid, bus.host_rdata}), 32'({1'b1, mem_model[8'h90]}));
    tx_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.tx_valid) begin
        tx_cnt++;
        check("s5_tx_data", 32'(bus.tx_data), 32'(mem_model[8'h00]));
      end
    end
    check("s5_one_tx", 32'(tx_cnt), 32'd1);
    check("s5_ovf_sticky", 32'(bus.spi_ovf), 32'd1);

    // Reset in the middle of an SPI read aborts it; a fresh read then works
    do_reset("s6");
    spi_word(10'h241);
    spi_word(10'h300);
    @(negedge clk);
    check("s6_in_spi_rd", 32'({bus.ram_en, bus.ram_we}), 32'b10);
    rst = 1'b1;
    #1;
    check("s6_abort", 32'({bus.busy, bus.ram_en, bus.tx_valid}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.tx_valid || bus.ram_en || bus.busy) bad++;
    end
    check("s6_quiet_after", 32'(bad), 32'd0);
    spi_word(10'h241);
    spi_word(10'h3FF);
    repeat (3) @(negedge clk);
    check("s6_new_read", 32'({bus.tx_valid, bus.tx_data}), 32'({1'b1, mem_model[8'h41]}));
    check("s6_no_ovf", 32'(bus.spi_ovf), 32'd0);

    // Randomized concurrent SPI (low half) and host (high half) traffic
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          sa = 8'($urandom_range(0, 127));
          sd = 8'($urandom);
          if ($urandom_range(0, 1) == 1) begin
            spi_word({2'b00, sa});
            spi_word({2'b01, sd});
            mem_model[sa] = sd;
            repeat (8) @(negedge clk);
          end else begin
            spi_word({2'b10, sa});
            spi_word({2'b11, sd});
            wait_tx(ok);
            check("rnd_tx_seen", 32'(ok), 32'd1);
            check("rnd_tx_data", 32'(bus.tx_data), 32'(mem_model[sa]));
            repeat ($urandom_range(0, 3)) @(negedge clk);
          end
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          ha  = 8'($urandom_range(128, 255));
          hd  = 8'($urandom);
          hwe = 1'($urandom_range(0, 1));
          bus.host_req = 1'b1; bus.host_we = hwe; bus.host_addr = ha; bus.host_wdata = hd;
          wait_gnt(ok2);
          bus.host_req = 1'b0;
          check("rnd_host_gnt", 32'(ok2), 32'd1);
          if (hwe) begin
            mem_model[ha] = hd;
          end else begin
            repeat (2) @(negedge clk);
            check("rnd_host_rd", 32'({bus.host_rvalid, bus.host_rdata}), 32'({1'b1, mem_model[ha]}));
          end
          @(negedge clk);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    join
    repeat (4) @(negedge clk);
    check("rnd_no_ovf", 32'(bus.spi_ovf), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== mem_model[i]) bad++;
    check("ram_image", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_cmd_arbiter.md
RAM_CMD_ARBITER -- requirements
Module: ram_cmd_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 8, SHALL set the RAM address width.
REQ-002 Parameter DATA_SIZE, default 8, SHALL set the RAM data width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 rx_valid  in  1  SHALL flag a 10-bit SPI-slave word on rx_data for one cycle.
REQ-006 rx_data  in  10  SHALL carry the command in [9:8] and the payload in [7:0].
REQ-007 tx_valid  out  1  SHALL pulse for one cycle when tx_data holds SPI read data.
REQ-008 tx_data  out  8  SHALL carry RAM read data back to the SPI slave.
REQ-009 host_req  in  1  SHALL be a level request from the local host, held until host_gnt.
REQ-010 host_we, host_addr, host_wdata  in  1/8/8  SHALL give the host operation type (1 = write), address and write data, held stable while host_req=1.
REQ-011 host_gnt  out  1  SHALL be a one-cycle pulse in the cycle the host operation reaches the RAM.
REQ-012 host_rvalid, host_rdata  out  1/8  SHALL return host read data, with host_rvalid as a one-cycle pulse.
REQ-013 ram_en, ram_we, ram_addr, ram_wdata  out  1/1/8/8  SHALL drive a single-port synchronous RAM.
REQ-014 ram_rdata  in  8  SHALL be valid in the cycle after a read is issued (ram_en=1, ram_we=0).
REQ-015 busy  out  1  SHALL be 1 whenever the FSM is not in IDLE.
REQ-016 spi_ovf  out  1  SHALL be a sticky SPI command-overflow flag.

Function
REQ-017 On rx_valid with cmd 00, the block SHALL latch rx_data[7:0] into wr_addr on the same edge, regardless of FSM state.
REQ-018 On rx_valid with cmd 10, the block SHALL latch rx_data[7:0] into rd_addr on the same edge, regardless of FSM state.
REQ-019 On rx_valid with cmd 01, the block SHALL set spi_pend, snapshotting op=write, wr_addr and rx_data[7:0].
REQ-020 On rx_valid with cmd 11, the block SHALL set spi_pend, snapshotting op=read and rd_addr; rx_data[7:0] is ignored.
REQ-021 An address command arriving while spi_pend=1 SHALL NOT alter the snapshotted operation.
REQ-022 A data command (01/11) arriving while spi_pend=1 SHALL be dropped and SHALL set spi_ovf=1 until reset.
REQ-023 FSM states SHALL be IDLE, SPI_WR, SPI_RD, SPI_RD_WAIT, HOST_WR, HOST_RD, HOST_RD_WAIT.
REQ-024 IDLE SHALL go to SPI_WR/SPI_RD on a winning SPI request, to HOST_WR/HOST_RD on a winning host request, and otherwise stay in IDLE.
REQ-025 SPI_WR, HOST_WR, SPI_RD_WAIT and HOST_RD_WAIT SHALL return to IDLE after 1 cycle.
REQ-026 SPI_RD SHALL go to SPI_RD_WAIT, and HOST_RD SHALL go to HOST_RD_WAIT.
REQ-027 Arbitration SHALL be round-robin: when both requests are present in IDLE, the requester not served last SHALL win; after reset, SPI wins the first tie.
REQ-028 RAM outputs SHALL be state-decoded.
  - SPI_WR/HOST_WR: ram_en=1, ram_we=1.
  - SPI_RD/HOST_RD: ram_en=1, ram_we=0.
  - All other states: ram_en=0, ram_we=0.
REQ-029 ram_addr and ram_wdata SHALL come from the SPI snapshot in SPI states and directly from host_addr/host_wdata in host states.
REQ-030 spi_pend SHALL clear on the edge leaving SPI_WR or SPI_RD_WAIT; a data command arriving on that same edge SHALL be accepted, not flagged.
REQ-031 host_gnt SHALL equal 1 exactly in HOST_WR and HOST_RD.
REQ-032 On the edge leaving SPI_RD_WAIT, ram_rdata SHALL be registered into tx_data, with tx_valid=1 for the following cycle only; tx_data SHALL hold until the next SPI read.
REQ-033 On the edge leaving HOST_RD_WAIT, ram_rdata SHALL be registered into host_rdata, with host_rvalid=1 for the following cycle only.
REQ-034 Latency from rx_valid (cmd 01/11) in cycle N with the FSM idle and no host request SHALL be: ram_en in N+2 and, for reads, tx_valid in N+4.
REQ-035 Host latency from host_req in an idle cycle M SHALL be: host_gnt in M+1 and, for reads, host_rvalid in M+3.

Reset
REQ-036 While rst=1, the block SHALL hold the FSM in IDLE and clear spi_pend, spi_ovf, wr_addr, rd_addr, tx_data, host_rdata and the round-robin pointer.
REQ-037 While rst=1, all outputs SHALL be 0.
REQ-038 Reset asserted mid-operation SHALL abort the operation with no RAM access and no tx_valid/host_rvalid pulse.

Verification
REQ-039 Scenario 1: SPI words 0x005, 0x1A5 -> ram_en=ram_we=1, ram_addr=0x05, ram_wdata=0xA5 two cycles after the second word.
REQ-040 Scenario 2: SPI words 0x205, 0x300 with RAM[0x05]=0xA5 -> tx_valid pulse with tx_data=0xA5, four cycles after 0x300.
REQ-041 Scenario 3: SPI write pending and host_req (read 0x10) in the same idle cycle after reset -> SPI served first; host_gnt follows after one idle cycle; host_rdata=RAM[0x10].
REQ-042 Scenario 4: host_req held continuously and SPI data commands every 6 cycles -> grants alternate SPI/host; neither requester is starved.
REQ-043 Scenario 5: two 0x3xx commands one cycle apart while the host holds the RAM -> second command dropped, spi_ovf=1, exactly one tx_valid.
REQ-044 Scenario 6: rst asserted during SPI_RD -> no tx_valid, busy=0, spi_pend=0; a new read completes normally after release.
